twofish_sbox_fill: RTL and testbench

Key-dependent S-box table builder for the Twofish core. It consumes the two 32-bit S-box key words s0/s1 from the RS-matrix key stage. It precomputes the four 256-entry, 8-bit keyed S-boxes of the 128-bit-key g-function, one index per cycle. The round engine then reads four S-box bytes per cycle from this block and applies MDS itself.

---
 rtl/twofish_sbox_fill.sv | 169 ++++++++++++++++
 tb/tb_twofish_sbox_fill.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/twofish_sbox_fill.sv
// Builds the four key-dependent Twofish S-boxes (128-bit key), one index per cycle,
// and serves registered 4-byte lookups. Optional macro: SBOX_READ_GUARD_EN (block reads until tables are valid).
module twofish_sbox_fill (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s0_i,
  input  logic [31:0] s1_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        tables_valid_o,
  input  logic        rd_en_i,
  input  logic [31:0] rd_x_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        rd_err_o
);

  // state   | meaning
  // IDLE    | waiting for start_i; tables hold last build (if any)
  // FILL    | writing entry cnt of all four S-boxes each cycle
  // DONE    | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  // 4-bit t-tables, nibble i at bits 4i+3:4i
  localparam logic [63:0] Q0T0 = 64'h4ACE_95B0_23F6_D718;
  localparam logic [63:0] Q0T1 = 64'hD907_6A4F_5321_8BCE;
  localparam logic [63:0] Q0T2 = 64'h1742_3F8C_09D6_E5AB;
  localparam logic [63:0] Q0T3 = 64'hAC58_03B9_E621_4F7D;
  localparam logic [63:0] Q1T0 = 64'h5CA0_4913_E67F_DB82;
  localparam logic [63:0] Q1T1 = 64'h809F_5AD6_73C4_B2E1;
  localparam logic [63:0] Q1T2 = 64'hF3B2_8DE0_A961_57C4;
  localparam logic [63:0] Q1T3 = 64'hA802_F746_ED3C_159B;

  function automatic logic [3:0] nib(input logic [63:0] tbl, input logic [3:0] idx);
    return tbl[{idx, 2'b00} +: 4];
  endfunction

  // sel=0 -> q0, sel=1 -> q1
  function automatic logic [7:0] qp(input logic sel, input logic [7:0] x);
    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
    a0 = x[7:4];
    b0 = x[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
    a2 = nib(sel ? Q1T0 : Q0T0, a1);
    b2 = nib(sel ? Q1T1 : Q0T1, b1);
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    a4 = nib(sel ? Q1T2 : Q0T2, a3);
    b4 = nib(sel ? Q1T3 : Q0T3, b3);
    return {b4, a4};
  endfunction

  state_t      state_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] k0_q, k1_q;
  logic        busy_q, done_q, valid_q;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;

  logic [7:0] sb0_mem [256];
  logic [7:0] sb1_mem [256];
  logic [7:0] sb2_mem [256];
  logic [7:0] sb3_mem [256];

  logic [7:0] wr0_d, wr1_d, wr2_d, wr3_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    wr0_d = qp(1'b1, qp(1'b0, qp(1'b0, cnt_q) ^ k0_q[7:0])   ^ k1_q[7:0]);
    wr1_d = qp(1'b0, qp(1'b0, qp(1'b1, cnt_q) ^ k0_q[15:8])  ^ k1_q[15:8]);
    wr2_d = qp(1'b1, qp(1'b1, qp(1'b0, cnt_q) ^ k0_q[23:16]) ^ k1_q[23:16]);
    wr3_d = qp(1'b0, qp(1'b1, qp(1'b1, cnt_q) ^ k0_q[31:24]) ^ k1_q[31:24]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      k0_q    <= 32'd0;
      k1_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            k0_q    <= s0_i;
            k1_q    <= s1_i;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          cnt_q <= cnt_d;
          if (cnt_q == 8'd255) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Table contents are deliberately not reset; the FSM abort stops further writes.
  always_ff @(posedge clk) begin
    if (state_q == ST_FILL) begin
      sb0_mem[cnt_q] <= wr0_d;
      sb1_mem[cnt_q] <= wr1_d;
      sb2_mem[cnt_q] <= wr2_d;
      sb3_mem[cnt_q] <= wr3_d;
    end
  end

`ifdef SBOX_READ_GUARD_EN
  logic rd_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      rd_err_q   <= rd_en_i && !valid_q;
      if (rd_en_i) begin
        if (!valid_q) rd_data_q <= 32'd0;
        else rd_data_q <= {sb3_mem[rd_x_i[31:24]], sb2_mem[rd_x_i[23:16]],
                           sb1_mem[rd_x_i[15:8]],  sb0_mem[rd_x_i[7:0]]};
      end
    end
  end

  assign rd_err_o = rd_err_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i)
        rd_data_q <= {sb3_mem[rd_x_i[31:24]], sb2_mem[rd_x_i[23:16]],
                      sb1_mem[rd_x_i[15:8]],  sb0_mem[rd_x_i[7:0]]};
    end
  end

  assign rd_err_o = 1'b0;
`endif

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign tables_valid_o = valid_q;
  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;

endmodule

// File: tb/tb_twofish_sbox_fill.sv
// Directed bench for twofish_sbox_fill: builds tables for several keys and checks
// timing, abort, read-during-write and lookups against an independent q-permutation model.
module tb_twofish_sbox_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s0_i, s1_i;
  logic        start_i;
  logic        busy_o, done_o, tables_valid_o;
  logic        rd_en_i;
  logic [31:0] rd_x_i;
  logic [31:0] rd_data_o;
  logic        rd_valid_o, rd_err_o;

  int checks = 0;
  int errors = 0;

  twofish_sbox_fill dut (
    .clk(clk), .rst(rst), .s0_i(s0_i), .s1_i(s1_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .tables_valid_o(tables_valid_o),
    .rd_en_i(rd_en_i), .rd_x_i(rd_x_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .rd_err_o(rd_err_o)
  );

  always #5 clk = ~clk;

  // Reference t-tables in natural index order: [perm][table][index]
  int tt [2][4][16] = '{
    '{'{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4},
      '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13},
      '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1},
      '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10}},
    '{'{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5},
      '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8},
      '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15},
      '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10}}
  };
  int qtab [2][256];

  function automatic int ror4(int v);
    return ((v >> 1) | ((v & 1) << 3)) & 15;
  endfunction

  function automatic int qcalc(int p, int x);
    int a, b, na, nb;
    a  = x / 16;
    b  = x % 16;
    na = a ^ b;
    nb = (a ^ ror4(b) ^ ((a * 8) % 16)) & 15;
    a  = tt[p][0][na];
    b  = tt[p][1][nb];
    na = a ^ b;
    nb = (a ^ ror4(b) ^ ((a * 8) % 16)) & 15;
    return tt[p][3][nb] * 16 + tt[p][2][na];
  endfunction

  // Entry x of S-box j for key words k0/k1
  function automatic int sbm(int j, int x, logic [31:0] k0, logic [31:0] k1);
    int kb0, kb1;
    kb0 = int'((k0 >> (8 * j)) & 32'hFF);
    kb1 = int'((k1 >> (8 * j)) & 32'hFF);
    case (j)
      0: return qtab[1][qtab[0][qtab[0][x] ^ kb0] ^ kb1];
      1: return qtab[0][qtab[0][qtab[1][x] ^ kb0] ^ kb1];
      2: return qtab[1][qtab[1][qtab[0][x] ^ kb0] ^ kb1];
      default: return qtab[0][qtab[1][qtab[1][x] ^ kb0] ^ kb1];
    endcase
  endfunction

  function automatic logic [31:0] word_m(logic [31:0] x, logic [31:0] k0, logic [31:0] k1);
    logic [31:0] r;
    r = 32'd0;
    for (int j = 0; j < 4; j++)
      r = r | (32'(sbm(j, int'((x >> (8 * j)) & 32'hFF), k0, k1)) << (8 * j));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done_o; returns cycles from the start edge to done and busy-high count.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = -1;
    nbusy = busy_o ? 1 : 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (done_o) begin
        lat = i;
        break;
      end
      if (busy_o) nbusy++;
    end
  endtask

  task automatic start_build(input logic [31:0] k0, input logic [31:0] k1);
    s0_i    = k0;
    s1_i    = k1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Back-to-back sweep of all indices, checking data and per-table bijection.
  task automatic read_all(input string tag, input logic [31:0] k0, input logic [31:0] k1);
    logic [255:0] seen [4];
    for (int j = 0; j < 4; j++) seen[j] = '0;
    rd_en_i = 1'b1;
    for (int x = 0; x < 256; x++) begin
      rd_x_i = {4{8'(x)}};
      tick();
      chk({tag, "_data"}, rd_data_o, word_m(rd_x_i, k0, k1));
      for (int j = 0; j < 4; j++) seen[j][rd_data_o[8*j +: 8]] = 1'b1;
    end
    chk({tag, "_valid"}, {31'd0, rd_valid_o}, 32'd1);
    rd_en_i = 1'b0;
    for (int j = 0; j < 4; j++) chk({tag, "_bijection"}, 32'($countones(seen[j])), 32'd256);
  endtask

  int lat, nbusy, ndone;
  logic [31:0] ka0, ka1, kb0, kb1, held;

  initial begin
    for (int p = 0; p < 2; p++)
      for (int x = 0; x < 256; x++) qtab[p][x] = qcalc(p, x);

    rst = 1'b1; start_i = 1'b0; s0_i = '0; s1_i = '0; rd_en_i = 1'b0; rd_x_i = '0;
    #12;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_valid", {31'd0, tables_valid_o}, 32'd0);
    chk("rst_rdata", rd_data_o, 32'd0);
    chk("rst_rvalid", {31'd0, rd_valid_o}, 32'd0);
    chk("rst_rerr", {31'd0, rd_err_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Build 1: all-zero key
    start_build(32'h0, 32'h0);
    chk("b1_busy_at_T", {31'd0, busy_o}, 32'd1);
    wait_done(lat, nbusy);
    chk("b1_latency", 32'(lat), 32'd256);
    chk("b1_busy_cycles", 32'(nbusy), 32'd256);
    chk("b1_busy_at_done", {31'd0, busy_o}, 32'd0);
    chk("b1_valid_at_done", {31'd0, tables_valid_o}, 32'd1);
    tick();
    chk("b1_done_single", {31'd0, done_o}, 32'd0);
    read_all("b1", 32'h0, 32'h0);
    held = rd_data_o;
    tick();
    chk("idle_rvalid", {31'd0, rd_valid_o}, 32'd0);
    chk("idle_rdata_hold", rd_data_o, held);

    // Build 2: read-during-write at entry 5, ignored restart at T+100
    ka0 = 32'h1234_5678; ka1 = 32'h9ABC_DEF0;
    kb0 = 32'hDEAD_BEEF; kb1 = 32'h0BAD_F00D;
    start_build(ka0, ka1);
    chk("b2_valid_fall", {31'd0, tables_valid_o}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    rd_en_i = 1'b1;
    rd_x_i  = 32'h0505_0505;
    tick();
`ifdef SBOX_READ_GUARD_EN
    chk("rw_same_entry_guarded", rd_data_o, 32'h0);
    chk("rw_err", {31'd0, rd_err_o}, 32'd1);
`else
    chk("rw_same_entry_old", rd_data_o, word_m(32'h0505_0505, 32'h0, 32'h0));
    chk("rw_err", {31'd0, rd_err_o}, 32'd0);
`endif
    chk("rw_rvalid", {31'd0, rd_valid_o}, 32'd1);
    tick();
`ifdef SBOX_READ_GUARD_EN
    chk("rw_after_write_guarded", rd_data_o, 32'h0);
`else
    chk("rw_after_write_new", rd_data_o, word_m(32'h0505_0505, ka0, ka1));
`endif
    rd_en_i = 1'b0;
    for (int i = 7; i < 99; i++) tick();
    s0_i = kb0; s1_i = kb1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    s0_i = 32'hFFFF_FFFF; s1_i = 32'h5555_AAAA;
    ndone = 0;
    lat   = -1;
    for (int i = 101; i <= 270; i++) begin
      tick();
      if (done_o) begin
        ndone++;
        if (lat < 0) lat = i;
      end
    end
    chk("b2_done_count", 32'(ndone), 32'd1);
    chk("b2_latency", 32'(lat), 32'd256);
    rd_en_i = 1'b1;
    rd_x_i  = 32'h0302_0100;
    tick();
    chk("b2_rd_0123", rd_data_o, word_m(32'h0302_0100, ka0, ka1));
    rd_x_i  = 32'hFFFF_FFFF;
    tick();
    chk("b2_rd_ff", rd_data_o, word_m(32'hFFFF_FFFF, ka0, ka1));
    rd_en_i = 1'b0;
    read_all("b2", ka0, ka1);

    // Build 3: reset mid-fill, then a fresh build
    start_build(32'hA5A5_0F0F, 32'h3C3C_C3C3);
    for (int i = 1; i < 50; i++) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_valid", {31'd0, tables_valid_o}, 32'd0);
    chk("abort_rdata", rd_data_o, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_idle_busy", {31'd0, busy_o}, 32'd0);
    start_build(32'h0102_0304, 32'hF0E0_D0C0);
    wait_done(lat, nbusy);
    chk("b3_latency", 32'(lat), 32'd256);
    chk("b3_busy_cycles", 32'(nbusy), 32'd256);
    tick();
    read_all("b3", 32'h0102_0304, 32'hF0E0_D0C0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
